amiga_kbd_mouse: RTL and testbench
==================================

// Module: amiga_kbd_mouse
// PURPOSE
//  Downstream consumer of the HID event interface (level-toggle strobe + type + data).
//  Keyboard events go through a small FIFO and out as the Amiga keyboard serial protocol
//  (KDAT/KCLK, CIA handshake, timeout resync). Mouse X/Y deltas build the 8-bit wrapping
//  position counters for JOY0DAT.
// PARAMETERS
//  CLK_HZ        28_000_000  clk frequency; all protocol timings derive from it
//  BIT_US        20          duration of each of the 3 phases per serial bit, in us
//  HS_TIMEOUT_MS 143         max wait for CIA handshake before resync
//  FIFO_DEPTH    8           keyboard event FIFO entries (power of 2)
// PORTS
//  clk             in   1  system clock
//  reset           in   1  synchronous, active-high
//  kbd_mouse_level in   1  event strobe; each toggle = one new event (asynchronous source)
//  kbd_mouse_type  in   2  0=mouse X delta, 1=mouse Y delta, 2=key, 3=ignored
//  kbd_mouse_data  in   8  X/Y: signed delta; key: [6:0] Amiga keycode, [7]=1 release
//  kbd_ack         in   1  CIA handshake, high while CIA holds KDAT low (asynchronous)
//  kbd_dat_n       out  1  KDAT line level (active low), idle 1
//  kbd_clk_n       out  1  KCLK line level (active low), idle 1
//  mouse_x         out  8  accumulated X position
//  mouse_y         out  8  accumulated Y position
//  kbd_overflow    out  1  sticky: a key event was dropped because the FIFO was full
//  kbd_reset       out  1  Ctrl-Amiga-Amiga reset request (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: kbd_dat_n=1, kbd_clk_n=1, mouse_x=0, mouse_y=0, kbd_overflow=0,
//   kbd_reset=0, FIFO empty, FSM in PWRUP. Reset mid-transfer aborts it; lines return idle.
//  Ingress: kbd_mouse_level passes a 2-FF synchroniser. A third register gives edge
//   detection. On the detect cycle, type/data are sampled directly; the source holds them
//   stable >=3 clk around each toggle. Event acts 1 cycle after detect.
//  Mouse: type0 -> mouse_x <= mouse_x + data; type1 -> mouse_y likewise. Mod-256 wrap,
//   no saturation (0xFF + 0x02 = 0x01).
//  Key: type2 pushes data into FIFO. If full: drop the event, set kbd_overflow.
//   Push and pop in the same cycle are both honoured.
//  Bit timing: T = CLK_HZ/1e6*BIT_US cycles. Each bit: dat_n = ~bit for T with clk_n=1,
//   then clk_n=0 for T, then clk_n=1 for T. After the 8th bit, dat_n returns to 1.
//  Wire byte: tx = {code[6:0], up}, sent MSB first (bit7 first).
//   Example: key 0x45 down -> tx 0x8A -> dat_n sequence 0,1,1,1,0,1,0,1.
//  FSM:
//   PWRUP  -> SEND 0xFD, then 0xFE (init/term), each with its own WAIT_ACK, then IDLE
//   IDLE   -> SEND when FIFO non-empty; the head is popped on leaving IDLE
//   SEND   -> 8 bits, then WAIT_ACK
//   WAIT_ACK: a rising edge of synchronised kbd_ack -> IDLE (or next PWRUP byte).
//    If HS_TIMEOUT_MS elapses first -> RESYNC.
//   RESYNC -> clock out one '1' bit, then WAIT_ACK(resync).
//    Ack -> SEND 0xF9 (lost-sync code), then resend the saved byte. Timeout -> RESYNC again.
//   kbd_ack edges outside WAIT_ACK are ignored. The saved byte is kept until acked.
// CONFIGURATION
//  KBD_RESET_SEQ_EN defined:
//   - Track held state of Ctrl 0x63, LAmiga 0x66, RAmiga 0x67 from dequeued key events.
//   - kbd_reset=1 while all three are held; it clears on the first release of any of them.
//   - Keycodes are still transmitted.
//  Undefined: kbd_reset tied 0; the port remains.
// STRUCTURE
//  Package amiga_kbd_pkg: event type constants (EV_MOUSE_X/EV_MOUSE_Y/EV_KEY);
//   KEY_INIT=8'hFD, KEY_TERM=8'hFE, KEY_LOST=8'hF9; KEY_CTRL/KEY_LAMIGA/KEY_RAMIGA;
//   FSM state enum.
//  Sub-module kbd_fifo: synchronous FIFO, FIFO_DEPTH x 8, with push/pop/full/empty.
//   The top level keeps ingress, mouse accumulators, serialiser FSM and timers.
// TESTING
//  1. After reset, ack each byte 100us after its 8th bit.
//     -> FD then FE serialised, lines then idle, FSM in IDLE.
//  2. Toggle level: type2 data 0x45, ack.
//     -> dat_n 0,1,1,1,0,1,0,1; 8 clk_n low pulses of T each.
//  3. Type0 data 0xFF, then type0 0x02, then type1 0x80.
//     -> mouse_x 0xFF then 0x01, mouse_y 0x80; no serial activity.
//  4. Withhold ack for >143ms after a key.
//     -> one resync '1' bit; after ack, F9 is sent, then the original byte is resent.
//  5. Push 10 keys with ack held off (DEPTH=8).
//     -> kbd_overflow=1; after acks, exactly 8 queued codes arrive in order.
//  6. With KBD_RESET_SEQ_EN: press 0x63, 0x66, 0x67 -> kbd_reset=1; release 0x66 -> 0.
//     Without the macro, kbd_reset stays 0.

Source files
------------

// File: rtl/amiga_kbd_pkg.sv
// Shared constants, state encodings and helpers for the Amiga keyboard/mouse bridge.
package amiga_kbd_pkg;

  localparam logic [1:0] EV_MOUSE_X = 2'd0;
  localparam logic [1:0] EV_MOUSE_Y = 2'd1;
  localparam logic [1:0] EV_KEY     = 2'd2;

  localparam logic [7:0] KEY_INIT = 8'hFD;
  localparam logic [7:0] KEY_TERM = 8'hFE;
  localparam logic [7:0] KEY_LOST = 8'hF9;

  localparam logic [6:0] KEY_CTRL   = 7'h63;
  localparam logic [6:0] KEY_LAMIGA = 7'h66;
  localparam logic [6:0] KEY_RAMIGA = 7'h67;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_ACK,
    ST_RESYNC
  } kbd_state_t;

  // What the pending handshake acknowledges
  typedef enum logic [1:0] {
    ACK_NORMAL,
    ACK_RESYNC,
    ACK_LOST
  } ack_mode_t;

  // Key event {up, code[6:0]} to the serial wire order {code[6:0], up}
  function automatic logic [7:0] wire_byte(input logic [7:0] ev);
    return {ev[6:0], ev[7]};
  endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous FIFO for keyboard events; DEPTH must be a power of two.
module kbd_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/amiga_kbd_mouse.sv
// HID event consumer: mouse position counters plus Amiga keyboard serial transmitter.
// Optional Ctrl-Amiga-Amiga reset detection is enabled by defining KBD_RESET_SEQ_EN.
module amiga_kbd_mouse
  import amiga_kbd_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 28_000_000,
  parameter int unsigned BIT_US        = 20,
  parameter int unsigned HS_TIMEOUT_MS = 143,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_mouse_level,
  input  logic [1:0] kbd_mouse_type,
  input  logic [7:0] kbd_mouse_data,
  input  logic       kbd_ack,
  output logic       kbd_dat_n,
  output logic       kbd_clk_n,
  output logic [7:0] mouse_x,
  output logic [7:0] mouse_y,
  output logic       kbd_overflow,
  output logic       kbd_reset
);
  localparam int unsigned T_CYC  = CLK_HZ / 1_000_000 * BIT_US;
  localparam int unsigned TO_CYC = CLK_HZ / 1000 * HS_TIMEOUT_MS;
  localparam int unsigned TW     = (T_CYC > 1) ? $clog2(T_CYC) : 1;
  localparam int unsigned OW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  // Synchronisers are not reset so that a held level never looks like an edge after reset
  logic [2:0] lvl_sync, ack_sync;
  logic       lvl_edge, ack_rise;

  always_ff @(posedge clk) begin
    lvl_sync <= {lvl_sync[1:0], kbd_mouse_level};
    ack_sync <= {ack_sync[1:0], kbd_ack};
  end

  assign lvl_edge = lvl_sync[2] ^ lvl_sync[1];
  assign ack_rise = ack_sync[1] & ~ack_sync[2];

  logic       ev_valid;
  logic [1:0] ev_type;
  logic [7:0] ev_data;

  always_ff @(posedge clk) begin
    if (reset) ev_valid <= 1'b0;
    else       ev_valid <= lvl_edge;
    if (lvl_edge) begin
      ev_type <= kbd_mouse_type;
      ev_data <= kbd_mouse_data;
    end
  end

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout;

  assign fifo_push = ev_valid && (ev_type == EV_KEY);

  kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (ev_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mouse_x      <= 8'h00;
      mouse_y      <= 8'h00;
      kbd_overflow <= 1'b0;
    end else if (ev_valid) begin
      case (ev_type)
        EV_MOUSE_X: mouse_x <= mouse_x + ev_data;
        EV_MOUSE_Y: mouse_y <= mouse_y + ev_data;
        EV_KEY:     if (fifo_full) kbd_overflow <= 1'b1;
        default:    ;
      endcase
    end
  end

  kbd_state_t    state;
  ack_mode_t     mode;
  logic          pwr_fd;
  logic [7:0]    saved, tx, load_byte;
  logic [2:0]    bit_cnt;
  logic [1:0]    phase;
  logic [TW-1:0] tick;
  logic [OW-1:0] to_cnt;
  logic          load;

  // Which byte (if any) starts transmission this cycle
  always_comb begin
    load      = 1'b0;
    load_byte = saved;
    fifo_pop  = 1'b0;
    case (state)
      ST_PWRUP: begin
        load      = 1'b1;
        load_byte = KEY_INIT;
      end
      ST_IDLE: if (!fifo_empty) begin
        load      = 1'b1;
        fifo_pop  = 1'b1;
        load_byte = wire_byte(fifo_dout);
      end
      ST_WAIT_ACK: if (ack_rise) begin
        if (mode == ACK_RESYNC) begin
          load      = 1'b1;
          load_byte = KEY_LOST;
        end else if (mode == ACK_LOST) begin
          load = 1'b1;
        end else if (pwr_fd) begin
          load      = 1'b1;
          load_byte = KEY_TERM;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_PWRUP;
      mode      <= ACK_NORMAL;
      pwr_fd    <= 1'b1;
      saved     <= 8'h00;
      tx        <= 8'h00;
      bit_cnt   <= 3'd0;
      phase     <= 2'd0;
      tick      <= '0;
      to_cnt    <= '0;
      kbd_dat_n <= 1'b1;
      kbd_clk_n <= 1'b1;
    end else begin
      case (state)
        ST_SEND, ST_RESYNC: begin
          // Three equal phases per bit: data setup, clock low, clock high
          if (tick == TW'(T_CYC - 1)) begin
            tick <= '0;
            case (phase)
              2'd0: begin
                phase     <= 2'd1;
                kbd_clk_n <= 1'b0;
              end
              2'd1: begin
                phase     <= 2'd2;
                kbd_clk_n <= 1'b1;
              end
              default: begin
                if (bit_cnt == 3'd7) begin
                  kbd_dat_n <= 1'b1;
                  state     <= ST_WAIT_ACK;
                  to_cnt    <= '0;
                end else begin
                  tx        <= {tx[6:0], 1'b0};
                  kbd_dat_n <= ~tx[6];
                  bit_cnt   <= bit_cnt + 3'd1;
                  phase     <= 2'd0;
                end
              end
            endcase
          end else begin
            tick <= tick + TW'(1);
          end
        end
        ST_WAIT_ACK: begin
          if (ack_rise) begin
            case (mode)
              ACK_RESYNC: mode <= ACK_LOST;
              ACK_LOST:   mode <= ACK_NORMAL;
              default: begin
                if (pwr_fd) begin
                  pwr_fd <= 1'b0;
                  saved  <= KEY_TERM;
                end else begin
                  state <= ST_IDLE;
                end
              end
            endcase
          end else if (to_cnt == OW'(TO_CYC - 1)) begin
            // Single '1' bit; the last-bit count ends it after one bit time
            state     <= ST_RESYNC;
            mode      <= ACK_RESYNC;
            kbd_dat_n <= 1'b0;
            bit_cnt   <= 3'd7;
            phase     <= 2'd0;
            tick      <= '0;
          end else begin
            to_cnt <= to_cnt + OW'(1);
          end
        end
        ST_PWRUP: saved <= load_byte;
        ST_IDLE:  if (load) saved <= load_byte;
        default:  state <= ST_IDLE;
      endcase

      if (load) begin
        state     <= ST_SEND;
        tx        <= load_byte;
        kbd_dat_n <= ~load_byte[7];
        bit_cnt   <= 3'd0;
        phase     <= 2'd0;
        tick      <= '0;
      end
    end
  end

`ifdef KBD_RESET_SEQ_EN
  logic held_ctrl, held_lamiga, held_ramiga;
  logic nxt_ctrl, nxt_lamiga, nxt_ramiga;

  // Held-key tracking follows events as they leave the FIFO
  always_comb begin
    nxt_ctrl   = held_ctrl;
    nxt_lamiga = held_lamiga;
    nxt_ramiga = held_ramiga;
    if (fifo_pop) begin
      if (fifo_dout[6:0] == KEY_CTRL)   nxt_ctrl   = ~fifo_dout[7];
      if (fifo_dout[6:0] == KEY_LAMIGA) nxt_lamiga = ~fifo_dout[7];
      if (fifo_dout[6:0] == KEY_RAMIGA) nxt_ramiga = ~fifo_dout[7];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_ctrl   <= 1'b0;
      held_lamiga <= 1'b0;
      held_ramiga <= 1'b0;
      kbd_reset   <= 1'b0;
    end else begin
      held_ctrl   <= nxt_ctrl;
      held_lamiga <= nxt_lamiga;
      held_ramiga <= nxt_ramiga;
      kbd_reset   <= nxt_ctrl & nxt_lamiga & nxt_ramiga;
    end
  end
`else
  assign kbd_reset = 1'b0;
`endif

endmodule

// File: tb/tb_amiga_kbd_mouse.sv
// Self-checking bench for amiga_kbd_mouse with shortened protocol timings.
module tb_amiga_kbd_mouse;
  localparam int unsigned T = 4;  // 1 MHz clock, 4 us per phase

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       kbd_mouse_level = 1'b0;
  logic [1:0] kbd_mouse_type = 2'd3;
  logic [7:0] kbd_mouse_data = 8'h00;
  logic       kbd_ack = 1'b0;
  logic       kbd_dat_n, kbd_clk_n, kbd_overflow, kbd_reset;
  logic [7:0] mouse_x, mouse_y;

  amiga_kbd_mouse #(
    .CLK_HZ(1_000_000), .BIT_US(4), .HS_TIMEOUT_MS(1), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .kbd_mouse_level(kbd_mouse_level),
    .kbd_mouse_type(kbd_mouse_type), .kbd_mouse_data(kbd_mouse_data),
    .kbd_ack(kbd_ack), .kbd_dat_n(kbd_dat_n), .kbd_clk_n(kbd_clk_n),
    .mouse_x(mouse_x), .mouse_y(mouse_y), .kbd_overflow(kbd_overflow),
    .kbd_reset(kbd_reset)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  bit bitq[$];
  bit expq[$];
  int lowcnt = 0;
  logic [7:0] mx = 8'h00, my = 8'h00;

  typedef struct {
    logic [1:0] typ;
    logic [7:0] data;
    logic [7:0] ex;
    logic [7:0] ey;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Received bit = inverse of KDAT sampled as KCLK falls
  always @(negedge kbd_clk_n) if (!reset) bitq.push_back(!kbd_dat_n);

  always @(negedge clk) begin
    if (reset) lowcnt = 0;
    else if (kbd_clk_n === 1'b0) lowcnt++;
    else if (lowcnt != 0) begin
      chk("clk_low_width", lowcnt, T);
      lowcnt = 0;
    end
  end

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) expq.push_back(b[i]);
  endtask

  task automatic push_key(input logic [7:0] ev);
    push_byte({ev[6:0], ev[7]});
  endtask

  task automatic chk_stream(input string name);
    int bad = -1;
    checks++;
    for (int i = 0; i < expq.size() && i < bitq.size(); i++)
      if (bad < 0 && bitq[i] != expq[i]) bad = i;
    if (bad < 0 && bitq.size() == expq.size()) passes++;
    else $display("FAIL %s: got %0d bits (first diff at %0d) expected %0d bits",
                  name, bitq.size(), bad, expq.size());
    bitq.delete();
    expq.delete();
  endtask

  task automatic wait_bits(input int n, input string name);
    int cyc = 0;
    while (bitq.size() < n && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (bitq.size() < n) begin
      checks++;
      $display("FAIL %s: timeout with %0d bits, expected %0d", name, bitq.size(), n);
    end
  endtask

  task automatic ack_after(input int n, input string name);
    wait_bits(n, name);
    repeat (100) @(negedge clk);
    kbd_ack = 1'b1;
    repeat (4) @(negedge clk);
    kbd_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_event(input logic [1:0] typ, input logic [7:0] data);
    kbd_mouse_type = typ;
    kbd_mouse_data = data;
    repeat (3) @(negedge clk);
    kbd_mouse_level = ~kbd_mouse_level;
    repeat (4) @(negedge clk);
    kbd_mouse_type = 2'd3;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rx, d;
    logic [1:0] t;
    vecs[0] = '{2'd0, 8'hFF, 8'hFF, 8'h00};
    vecs[1] = '{2'd0, 8'h02, 8'h01, 8'h00};
    vecs[2] = '{2'd1, 8'h80, 8'h01, 8'h80};
    vecs[3] = '{2'd3, 8'h55, 8'h01, 8'h80};
    vecs[4] = '{2'd1, 8'h81, 8'h01, 8'h01};

    // Reset values
    repeat (5) @(negedge clk);
    chk("rst_dat_n", kbd_dat_n, 1);
    chk("rst_clk_n", kbd_clk_n, 1);
    chk("rst_mouse_x", mouse_x, 0);
    chk("rst_mouse_y", mouse_y, 0);
    chk("rst_overflow", kbd_overflow, 0);
    chk("rst_kbd_reset", kbd_reset, 0);
    reset = 1'b0;

    // Power-up: init then term code, each acknowledged
    push_byte(8'hFD);
    push_byte(8'hFE);
    ack_after(8, "pwrup_fd");
    ack_after(16, "pwrup_fe");
    chk_stream("pwrup_stream");
    repeat (200) @(negedge clk);
    chk("idle_no_bits", bitq.size(), 0);
    chk("idle_dat_n", kbd_dat_n, 1);
    chk("idle_clk_n", kbd_clk_n, 1);

    // Key 0x45 down -> wire byte 0x8A
    send_event(2'd2, 8'h45);
    push_key(8'h45);
    wait_bits(8, "key45");
    rx = 8'h00;
    for (int i = 0; i < 8 && i < bitq.size(); i++) rx = {rx[6:0], bitq[i]};
    chk("key45_wire", rx, 8'h8A);
    ack_after(8, "key45");
    chk_stream("key45_stream");

    // Mouse vectors, including wrap and ignored type
    for (int i = 0; i < 5; i++) begin
      send_event(vecs[i].typ, vecs[i].data);
      chk($sformatf("vec%0d_x", i), mouse_x, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), mouse_y, vecs[i].ey);
    end
    chk("mouse_no_serial", bitq.size(), 0);

    // Random mouse traffic against modular-sum model
    mx = vecs[4].ex;
    my = vecs[4].ey;
    for (int i = 0; i < 30; i++) begin
      t = 2'($urandom_range(0, 3));
      if (t == 2'd2) t = 2'd3;
      d = 8'($urandom);
      if (t == 2'd0) mx = mx + d;
      if (t == 2'd1) my = my + d;
      send_event(t, d);
      chk($sformatf("rnd%0d_x", i), mouse_x, mx);
      chk($sformatf("rnd%0d_y", i), mouse_y, my);
    end

    // Random keys (codes below 0x40)
    for (int i = 0; i < 4; i++) begin
      d = {1'($urandom), 1'b0, 6'($urandom)};
      send_event(2'd2, d);
      push_key(d);
      ack_after(8, "rndkey");
    end
    chk_stream("rndkey_stream");

    // Handshake timeout: resync bit, lost-sync code, then the original byte
    send_event(2'd2, 8'h20);
    push_key(8'h20);
    expq.push_back(1'b1);
    push_byte(8'hF9);
    push_key(8'h20);
    wait_bits(8, "to_key");
    repeat (900) @(negedge clk);
    chk("no_early_resync", bitq.size(), 8);
    ack_after(9, "to_resync");
    ack_after(17, "to_lost");
    ack_after(25, "to_resend");
    chk_stream("timeout_stream");

    // Overflow: first key goes straight on the wire, next 8 fill the FIFO, 10th drops
    chk("ovf_before", kbd_overflow, 0);
    for (int i = 0; i < 10; i++) send_event(2'd2, 8'(8'h10 + i));
    chk("ovf_after", kbd_overflow, 1);
    for (int i = 0; i < 9; i++) begin
      push_key(8'(8'h10 + i));
      ack_after(8 * (i + 1), "ovf_ack");
    end
    repeat (300) @(negedge clk);
    chk_stream("ovf_stream");

    // Ctrl-Amiga-Amiga
    send_event(2'd2, 8'h63); push_key(8'h63); ack_after(8, "cra0");
    send_event(2'd2, 8'h66); push_key(8'h66); ack_after(16, "cra1");
    chk("cra_partial", kbd_reset, 0);
    send_event(2'd2, 8'h67); push_key(8'h67); ack_after(24, "cra2");
`ifdef KBD_RESET_SEQ_EN
    chk("cra_held", kbd_reset, 1);
`else
    chk("cra_held", kbd_reset, 0);
`endif
    send_event(2'd2, 8'hE6); push_key(8'hE6); ack_after(32, "cra3");
    chk("cra_release", kbd_reset, 0);
    chk_stream("cra_stream");

    // Reset in the middle of a transfer
    send_event(2'd0, 8'h11);
    send_event(2'd2, 8'h30);
    wait_bits(3, "midrst");
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_dat_n", kbd_dat_n, 1);
    chk("midrst_clk_n", kbd_clk_n, 1);
    chk("midrst_mouse_x", mouse_x, 0);
    chk("midrst_overflow", kbd_overflow, 0);
    bitq.delete();
    expq.delete();
    reset = 1'b0;
    push_byte(8'hFD);
    push_byte(8'hFE);
    ack_after(8, "midrst_fd");
    ack_after(16, "midrst_fe");
    repeat (200) @(negedge clk);
    chk_stream("midrst_stream");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
